// File: rtl/pe_opsum_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_opsum_arbiter: round-robin merge of NUM_PE opsum streams into one GLB   |
// | write port through a 2-entry FIFO, with per-pass word counting.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pe_opsum_arbiter #(
    parameter int NUM_PE         = 4,
    parameter int PSUM_DATA_SIZE = 8,
    parameter int ID_BIT         = 2,
    parameter int CNT_BIT        = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic [NUM_PE*(PSUM_DATA_SIZE+1)-1:0]  pe_opsum_in,
    output logic [NUM_PE-1:0]                     pe_opsum_ready,
    input  logic [CNT_BIT-1:0]                    pass_len,
    output logic [PSUM_DATA_SIZE:0]               glb_opsum_out,
    output logic [ID_BIT-1:0]                     glb_opsum_id,
    input  logic                                  glb_ready,
    output logic                                  pass_done,
    output logic                                  busy
);

    localparam int W = PSUM_DATA_SIZE + 1;

    logic [NUM_PE-1:0]         pe_en;
    logic [PSUM_DATA_SIZE-1:0] pe_data [NUM_PE];

    generate
        for (genvar i = 0; i < NUM_PE; i++) begin : g_unpack
            assign pe_en[i]   = pe_opsum_in[i*W + PSUM_DATA_SIZE];
            assign pe_data[i] = pe_opsum_in[i*W +: PSUM_DATA_SIZE];
        end
    endgenerate

    logic [ID_BIT-1:0]         rr_ptr;
    logic [ID_BIT-1:0]         grant;
    logic                      grant_vld;
    logic [PSUM_DATA_SIZE-1:0] grant_data;
    logic [2*NUM_PE-1:0]       rot;

    // Rotate the doubled enable vector so bit k is PE (rr_ptr+k) mod NUM_PE;
    // the lowest set bit is the next PE in round-robin order.
    always_comb begin
        int off;
        int sum;
        off        = 0;
        sum        = 0;
        grant      = '0;
        grant_vld  = 1'b0;
        grant_data = '0;
        rot        = {pe_en, pe_en} >> rr_ptr;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_vld = 1'b1;
                off       = k;
            end
        end
        sum = int'(rr_ptr) + off;
        if (sum >= NUM_PE) begin
            sum = sum - NUM_PE;
        end
        grant = ID_BIT'(sum);
        for (int i = 0; i < NUM_PE; i++) begin
            if (i == sum) begin
                grant_data = pe_data[i];
            end
        end
    end

    logic [1:0]                count;
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [PSUM_DATA_SIZE-1:0] fifo_data [2];
    logic [ID_BIT-1:0]         fifo_id   [2];
    logic [CNT_BIT-1:0]        xfer_cnt;
    logic                      push;
    logic                      pop;
    logic [NUM_PE-1:0]         one_hot;

    assign one_hot = {{(NUM_PE-1){1'b0}}, 1'b1} << grant;

    // rst gates ready directly so PEs see it drop the instant reset asserts.
    assign pe_opsum_ready = (!rst && enable && (count != 2'd2) && grant_vld)
                            ? one_hot : '0;

    assign push = |pe_opsum_ready;
    assign pop  = (count != 2'd0) && glb_ready;

    assign glb_opsum_out = {(count != 2'd0), fifo_data[rd_ptr]};
    assign glb_opsum_id  = fifo_id[rd_ptr];
    assign busy          = (count != 2'd0) | (|pe_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            rr_ptr       <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_id[0]   <= '0;
            fifo_id[1]   <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= grant_data;
                fifo_id[wr_ptr]   <= grant;
                wr_ptr            <= ~wr_ptr;
                rr_ptr            <= (int'(grant) == NUM_PE - 1) ? '0 : grant + 1'b1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt  <= '0;
            pass_done <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            if (pop) begin
                if (pass_len == '0) begin
                    xfer_cnt <= '0;
                end else if (xfer_cnt == pass_len - 1'b1) begin
                    xfer_cnt  <= '0;
                    pass_done <= 1'b1;
                end else begin
                    xfer_cnt <= xfer_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
